// File: rtl/mbist_pkg.sv
// Shared types and helpers for the March C- memory BIST engine.
// Backgrounds are built at BG_W bits and truncated by the user.
package mbist_pkg;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_M0    = 4'd1,
    S_M1    = 4'd2,
    S_M2    = 4'd3,
    S_M3    = 4'd4,
    S_M4    = 4'd5,
    S_M5    = 4'd6,
    S_CHECK = 4'd7,
    S_DONE  = 4'd8
  } state_e;

  localparam logic [1:0] MODE_SOLID = 2'd0;
  localparam logic [1:0] MODE_CHKB  = 2'd1;
  localparam logic [1:0] MODE_USER  = 2'd2;

  localparam int BG_W = 64;
  localparam logic [BG_W-1:0] CHKB_SEED = {32{2'b01}};

  // Reserved mode code 3 falls through to the solid background.
  function automatic logic [BG_W-1:0] bg(
    input logic [1:0]      mode,
    input logic [BG_W-1:0] pat,
    input logic            a0
  );
    logic [BG_W-1:0] r;
    case (mode)
      MODE_CHKB: r = CHKB_SEED ^ {BG_W{a0}};
      MODE_USER: r = pat;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mbist_addr_gen.sv
// Up/down address walker with non-power-of-two wrap
// and a read/write phase toggle for two-cycle elements.
module mbist_addr_gen #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  input  logic              dual,
  input  logic              down,
  output logic [ADDR_W-1:0] addr,
  output logic              phase,
  output logic              last
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic [ADDR_W-1:0] nxt;

  always_comb begin
    nxt = '0;
    if (down)
      nxt = (addr == '0) ? LAST : addr - 1'b1;
    else
      nxt = (addr == LAST) ? '0 : addr + 1'b1;
  end

  assign last = down ? (addr == '0) : (addr == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      phase <= 1'b0;
    end else if (load) begin
      addr  <= load_down ? LAST : '0;
      phase <= 1'b0;
    end else if (step) begin
      if (dual && !phase) begin
        phase <= 1'b1;
      end else begin
        phase <= 1'b0;
        addr  <= nxt;
      end
    end
  end

endmodule

// File: rtl/mbist_march_ctrl.sv
// March C- BIST engine: FSM, access generation, compare
// pipeline and first-fail diagnostics.
module mbist_march_ctrl
  import mbist_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic              stop_on_fail,
  input  logic [DATA_W-1:0] user_pat,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_act,
  output logic [CNT_W-1:0]  fail_cnt
);

  state_e state, nstate;

  logic              in_m, dual, down;
  logic              is_rd, wpol, rpol;
  logic              accept, acc, mism, halt, elem_end;
  logic              ld, ld_down;
  logic [ADDR_W-1:0] addr;
  logic              phase, last;
  logic [1:0]        mode_q;
  logic [DATA_W-1:0] pat_q, bgd;
  logic              cmp_v;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] cadr_q;

  assign in_m = (state == S_M0) || (state == S_M1) ||
                (state == S_M2) || (state == S_M3) ||
                (state == S_M4) || (state == S_M5);
  assign dual = (state == S_M1) || (state == S_M2) ||
                (state == S_M3) || (state == S_M4);
  assign down = (state == S_M3) || (state == S_M4) ||
                (state == S_M5);
  assign wpol = (state == S_M1) || (state == S_M3);
  assign rpol = (state == S_M2) || (state == S_M4);
  assign is_rd = dual ? ~phase : (state == S_M5);

  assign bgd = DATA_W'(bg(mode_q, BG_W'(pat_q), addr[0]));

  assign accept = start &&
                  ((state == S_IDLE) || (state == S_DONE));
  assign mism = cmp_v && (mem_rdata != exp_q);
  assign halt = stop_on_fail && mism;

  // Reset, abort and a stopping mismatch all cut the access this cycle.
  assign acc = in_m && !rst && !abort && !halt;

  assign mem_en    = acc;
  assign mem_we    = acc && !is_rd;
  assign mem_addr  = acc ? addr : '0;
  assign mem_wdata = mem_we ? (bgd ^ {DATA_W{wpol}}) : '0;

  assign busy = in_m || (state == S_CHECK);
  assign done = (state == S_DONE);

  assign elem_end = last && (!dual || phase);
  assign ld       = accept || (acc && elem_end);
  assign ld_down  = (state == S_M2) || (state == S_M3) ||
                    (state == S_M4);

  mbist_addr_gen #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_agen (
    .clk       (clk),
    .rst       (rst),
    .load      (ld),
    .load_down (ld_down),
    .step      (acc),
    .dual      (dual),
    .down      (down),
    .addr      (addr),
    .phase     (phase),
    .last      (last)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      S_IDLE, S_DONE: if (start) nstate = S_M0;
      S_M0, S_M1, S_M2, S_M3, S_M4, S_M5: begin
        if (abort || halt) nstate = S_DONE;
        else if (elem_end) begin
          unique case (state)
            S_M0:    nstate = S_M1;
            S_M1:    nstate = S_M2;
            S_M2:    nstate = S_M3;
            S_M3:    nstate = S_M4;
            S_M4:    nstate = S_M5;
            default: nstate = S_CHECK;
          endcase
        end
      end
      S_CHECK: nstate = S_DONE;
      default: nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_SOLID;
      pat_q  <= '0;
    end else if (accept) begin
      mode_q <= mode;
      pat_q  <= user_pat;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      cmp_v  <= 1'b0;
      exp_q  <= '0;
      cadr_q <= '0;
    end else begin
      cmp_v <= acc && is_rd;
      if (acc && is_rd) begin
        exp_q  <= bgd ^ {DATA_W{rpol}};
        cadr_q <= addr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || accept) begin
      pass      <= 1'b0;
      fail_cnt  <= '0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_act  <= '0;
    end else begin
      if (state == S_CHECK)
        pass <= !abort && (fail_cnt == '0) && !mism;
      // fail_cnt==0 doubles as "no mismatch seen yet" since it saturates.
      if (mism && !abort) begin
        if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
        if (fail_cnt == '0) begin
          fail_addr <= cadr_q;
          fail_exp  <= exp_q;
          fail_act  <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Directed bench for mbist_march_ctrl: fault-injecting RAM
// models for a 16-word and a 12-word instance.
module tb_mbist_march_ctrl;

  localparam int DA = 16;
  localparam int DB = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, start_b = 1'b0, abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       sof = 1'b0;
  logic [7:0] pat = 8'h00;
  bit         stuck = 1'b0, coup = 1'b0;

  logic       mem_en, mem_we, busy, done, pass;
  logic [3:0] mem_addr, fail_addr;
  logic [7:0] mem_wdata, mem_rdata, fail_exp, fail_act, fail_cnt;

  logic       mem_en_b, mem_we_b, busy_b, done_b, pass_b;
  logic [3:0] mem_addr_b, fail_addr_b;
  logic [7:0] mem_wdata_b, mem_rdata_b, fail_exp_b, fail_act_b;
  logic [7:0] fail_cnt_b;

  mbist_march_ctrl #(.DEPTH(DA), .DATA_W(8), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .mode(mode), .stop_on_fail(sof), .user_pat(pat),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_exp(fail_exp),
    .fail_act(fail_act), .fail_cnt(fail_cnt)
  );

  mbist_march_ctrl #(.DEPTH(DB), .DATA_W(8), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .abort(abort),
    .mode(mode), .stop_on_fail(sof), .user_pat(pat),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .busy(busy_b), .done(done_b), .pass(pass_b),
    .fail_addr(fail_addr_b), .fail_exp(fail_exp_b),
    .fail_act(fail_act_b), .fail_cnt(fail_cnt_b)
  );

  logic [7:0] ram_a [DA];
  logic [7:0] ram_b [DB];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram_a[mem_addr] <= mem_wdata;
      if (coup && mem_addr == 4'd3) ram_a[4] <= ram_a[4] ^ 8'h80;
    end
    if (mem_en && !mem_we)
      mem_rdata <= ram_a[mem_addr] |
                   ((stuck && mem_addr == 4'd5) ? 8'h01 : 8'h00);
  end

  always @(posedge clk) begin
    if (mem_en_b && mem_we_b && mem_addr_b < 4'(DB))
      ram_b[mem_addr_b] <= mem_wdata_b;
    if (mem_en_b && !mem_we_b && mem_addr_b < 4'(DB))
      mem_rdata_b <= ram_b[mem_addr_b];
  end

  int cyc_a = 0, cyc_b = 0;
  always @(posedge clk) cyc_a <= start ? 1 : cyc_a + 1;
  always @(posedge clk) cyc_b <= start_b ? 1 : cyc_b + 1;

  // Reference March C- order: k-th access of a fault-free run.
  function automatic bit acc_ok(input int k, input int d,
                                input logic [1:0] md, input logic [7:0] up,
                                input int a_act, input bit we_act,
                                input logic [7:0] wd_act);
    int a, j; bit we, pol; logic [7:0] b;
    pol = 1'b0;
    if (k < d) begin a = k; we = 1'b1; end
    else if (k < 3*d) begin j = k-d; a = j/2; we = j[0]; pol = 1'b1; end
    else if (k < 5*d) begin j = k-3*d; a = j/2; we = j[0]; end
    else if (k < 7*d) begin j = k-5*d; a = d-1-j/2; we = j[0]; pol = 1'b1; end
    else if (k < 9*d) begin j = k-7*d; a = d-1-j/2; we = j[0]; end
    else begin a = d-1-(k-9*d); we = 1'b0; end
    case (md)
      2'd1:    b = a[0] ? 8'hAA : 8'h55;
      2'd2:    b = up;
      default: b = 8'h00;
    endcase
    if (a_act != a || we_act != we) return 1'b0;
    if (we && wd_act != (b ^ {8{pol}})) return 1'b0;
    return 1'b1;
  endfunction

  int acc_a = 0, oerr_a = 0, lastc_a = 0;
  int acc_b = 0, oerr_b = 0, maxa_b = 0;

  always @(negedge clk) begin
    if (start) begin
      acc_a <= 0; oerr_a <= 0; lastc_a <= 0;
    end else if (mem_en) begin
      if (!acc_ok(acc_a, DA, mode, pat, int'(mem_addr), mem_we, mem_wdata))
        oerr_a <= oerr_a + 1;
      acc_a   <= acc_a + 1;
      lastc_a <= cyc_a;
    end
  end

  always @(negedge clk) begin
    if (start_b) begin
      acc_b <= 0; oerr_b <= 0; maxa_b <= 0;
    end else if (mem_en_b) begin
      if (!acc_ok(acc_b, DB, mode, pat, int'(mem_addr_b), mem_we_b,
                  mem_wdata_b))
        oerr_b <= oerr_b + 1;
      if (int'(mem_addr_b) > maxa_b) maxa_b <= int'(mem_addr_b);
      acc_b <= acc_b + 1;
    end
  end

  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint req);
    n_vec++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
               nm, act, act, req, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_a(output int dc);
    dc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done) begin dc = cyc_a; break; end
    end
  endtask

  typedef struct {
    logic [1:0] md;
    logic [7:0] up;
    bit         so, stk, cpl;
    int         dcyc;
    bit         ps;
    int         cnt, fa;
    logic [7:0] fe, fx;
    int         accs, lastc;
  } vec_t;

  vec_t tbl [6];
  int   dc;

  initial begin
    tbl[0] = '{2'd0, 8'h00, 0, 0, 0, 162, 1, 0, 0, 8'h00, 8'h00, 160, 160};
    tbl[1] = '{2'd0, 8'h00, 0, 1, 0, 162, 0, 3, 5, 8'h00, 8'h01, 160, 160};
    tbl[2] = '{2'd0, 8'h00, 1, 1, 0,  29, 0, 1, 5, 8'h00, 8'h01,  27,  27};
    tbl[3] = '{2'd2, 8'hA5, 0, 0, 1, 162, 0, 4, 4, 8'hA5, 8'h25, 160, 160};
    tbl[4] = '{2'd1, 8'h00, 0, 0, 0, 162, 1, 0, 0, 8'h00, 8'h00, 160, 160};
    tbl[5] = '{2'd3, 8'h3C, 0, 0, 0, 162, 1, 0, 0, 8'h00, 8'h00, 160, 160};

    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_cnt", fail_cnt, 0);
    chk("rst_en", mem_en, 0);

    tick();
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 1);
    wait_done_a(dc);
    chk("sa_done_cyc", dc, 162);
    chk("sa_pass", pass, 1);

    for (int i = 0; i < 6; i++) begin
      tick();
      mode = tbl[i].md; pat = tbl[i].up; sof = tbl[i].so;
      stuck = tbl[i].stk; coup = tbl[i].cpl;
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_done_a(dc);
      chk($sformatf("v%0d_done_cyc", i), dc, tbl[i].dcyc);
      chk($sformatf("v%0d_busy", i), busy, 0);
      chk($sformatf("v%0d_pass", i), pass, tbl[i].ps);
      chk($sformatf("v%0d_cnt", i), fail_cnt, tbl[i].cnt);
      chk($sformatf("v%0d_faddr", i), fail_addr, tbl[i].fa);
      chk($sformatf("v%0d_fexp", i), fail_exp, tbl[i].fe);
      chk($sformatf("v%0d_fact", i), fail_act, tbl[i].fx);
      chk($sformatf("v%0d_accs", i), acc_a, tbl[i].accs);
      chk($sformatf("v%0d_last_acc", i), lastc_a, tbl[i].lastc);
      chk($sformatf("v%0d_order_err", i), oerr_a, 0);
    end

    tick();
    mode = 2'd0; sof = 1'b0; stuck = 1'b1; coup = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc_a < 50) tick();
    rst = 1'b1;
    #1;
    chk("rstmid_en", mem_en, 0);
    chk("rstmid_we", mem_we, 0);
    tick();
    rst = 1'b0;
    #1;
    chk("rstmid_busy", busy, 0);
    chk("rstmid_done", done, 0);
    chk("rstmid_pass", pass, 0);
    chk("rstmid_cnt", fail_cnt, 0);
    chk("rstmid_faddr", fail_addr, 0);
    chk("rstmid_fexp", fail_exp, 0);
    chk("rstmid_fact", fail_act, 0);
    chk("rstmid_addr", mem_addr, 0);
    chk("rstmid_wdata", mem_wdata, 0);

    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc_a < 40) tick();
    abort = 1'b1;
    #1;
    chk("abort_en", mem_en, 0);
    tick();
    abort = 1'b0;
    chk("abort_done", done, 1);
    chk("abort_pass", pass, 0);
    chk("abort_busy", busy, 0);
    chk("abort_cnt", fail_cnt, 1);
    chk("abort_faddr", fail_addr, 5);
    chk("abort_fact", fail_act, 8'h01);

    tick();
    stuck = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (cyc_a < 10) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done_a(dc);
    chk("busy_start_done_cyc", dc, 152);
    chk("busy_start_pass", pass, 1);
    chk("busy_start_accs", acc_a, 150);

    tick();
    mode = 2'd1;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    dc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (done_b) begin dc = cyc_b; break; end
    end
    chk("d12_done_cyc", dc, 122);
    chk("d12_pass", pass_b, 1);
    chk("d12_cnt", fail_cnt_b, 0);
    chk("d12_accs", acc_b, 120);
    chk("d12_max_addr", maxa_b, 11);
    chk("d12_order_err", oerr_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
